// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin one-hot grant with transaction hold and starvation watchdog
module bus_grant_arbiter #(
  parameter int INPUTS = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int COUNTER_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUTS-1:0]      request,
  output logic [INPUTS-1:0]      grant,
  output logic                   grantValid,
  output logic [INDEX_WIDTH-1:0] grantIndex,
  output logic                   timeout
);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state;
  logic [COUNTER_WIDTH-1:0] count;
  logic [INPUTS-1:0] eligible;
  logic [INDEX_WIDTH-1:0] winner;
  logic held, trig, found;
  assign grantValid = |grant;
  // Descending scan so the last hit is the first index after the pointer.
  always_comb begin
    held = state == GRANTED && request[grantIndex];
    trig = TIMEOUT_CYCLES > 0 && held && count == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
    eligible = trig ? request & ~(INPUTS'(1) << grantIndex) : request;
    found = 1'b0;
    winner = '0;
    for (int i = INPUTS; i >= 1; i--) begin
      if (eligible[(int'(grantIndex) + i) % INPUTS]) begin
        found = 1'b1;
        winner = INDEX_WIDTH'((int'(grantIndex) + i) % INPUTS);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grantIndex <= INDEX_WIDTH'(INPUTS - 1);
      count <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= trig;
      if (held && !trig) count <= count + 1'b1;
      else begin
        count <= '0;
        if (found) begin
          grant <= INPUTS'(1) << winner;
          grantIndex <= winner;
          state <= GRANTED;
        end else if (!held) begin
          grant <= '0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bus_grant_arbiter.sv
// tb_bus_grant_arbiter: directed vector table plus watchdog sequences for bus_grant_arbiter
module tb_bus_grant_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] request = '0;
  logic [3:0] grant;
  logic grantValid;
  logic [1:0] grantIndex;
  logic timeout;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] idx;
    logic to;
  } vec_t;
  vec_t vecs[$];
  logic [3:0] g_log[20];
  logic to_log[20];
  bus_grant_arbiter #(.INPUTS(4), .INDEX_WIDTH(2), .TIMEOUT_CYCLES(8), .COUNTER_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .request(request), .grant(grant),
    .grantValid(grantValid), .grantIndex(grantIndex), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] g, logic [1:0] i, logic t);
    vec_t v;
    v.rst = r; v.req = q; v.g = g; v.idx = i; v.to = t;
    return v;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(logic r, logic [3:0] q);
    rst = r;
    request = q;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int pulses, bad;
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0010, 2'd1, 0));
    vecs.push_back(mk(0, 4'b1101, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b0111, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'd2, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 2'd0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 2'd2, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 2'd3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 0));
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].req);
      check($sformatf("vec%0d grant", k), 32'(grant), 32'(vecs[k].g));
      check($sformatf("vec%0d index", k), 32'(grantIndex), 32'(vecs[k].idx));
      check($sformatf("vec%0d valid", k), 32'(grantValid), 32'(|vecs[k].g));
      check($sformatf("vec%0d timeout", k), 32'(timeout), 32'(vecs[k].to));
    end
    // Watchdog handover from master 0 to master 2 and back.
    step(1, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      step(0, 4'b0101);
      g_log[c] = grant;
      to_log[c] = timeout;
    end
    bad = 0;
    for (int c = 0; c < 8; c++) if (g_log[c] !== 4'b0001 || to_log[c] !== 1'b0) bad++;
    check("wd hold 8 cycles", 32'(bad), 0);
    check("wd handover grant", 32'(g_log[8]), 32'b0100);
    check("wd handover pulse", 32'(to_log[8]), 1);
    check("wd pulse one cycle", 32'(to_log[9]), 0);
    check("wd hold after handover", 32'(g_log[9]), 32'b0100);
    check("wd return grant", 32'(g_log[16]), 32'b0001);
    check("wd return pulse", 32'(to_log[16]), 1);
    // Lone master: held through timeouts.
    step(1, 4'b0000);
    pulses = 0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      step(0, 4'b0001);
      if (grant !== 4'b0001) bad++;
      if (timeout === 1'b1) begin
        pulses++;
        if (c % 8 != 0) bad++;
      end
    end
    check("lone grant held", 32'(bad), 0);
    check("lone pulse count", 32'(pulses), 3);
    // Release coinciding with watchdog trigger is a plain release.
    step(1, 4'b0000);
    for (int c = 0; c < 8; c++) step(0, 4'b0101);
    check("pre-trigger grant", 32'(grant), 32'b0001);
    step(0, 4'b0100);
    check("release+trig grant", 32'(grant), 32'b0100);
    check("release+trig no pulse", 32'(timeout), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_grant_arbiter.md
Name: bus_grant_arbiter

Overview:
- Round-robin arbiter sitting directly upstream of the one-hot select mux on shared bus paths.
- Registers a one-hot grant that drives the mux `select` input, so the granted master's signals pass to the shared slave.
- Holds a grant for the whole transaction, i.e. while the requester keeps `request` high.
- A hold-time watchdog stops a single master from starving the others.

Parameters:
- INPUTS, 4, number of requesters; legal range 2..8, matching the mux input counts.
- INDEX_WIDTH, 2, width of grantIndex; must equal ceil(log2(INPUTS)), minimum 1.
- TIMEOUT_CYCLES, 256, maximum continuous grant length in cycles; 0 disables the watchdog.
- COUNTER_WIDTH, 9, width of the hold counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- request  input  INPUTS  per-master request; held high for the whole transaction.
- grant  output  INPUTS  registered one-hot grant; connects to mux `select`.
- grantValid  output  1  high when any grant bit is set; equals |grant.
- grantIndex  output  INDEX_WIDTH  binary index of the current or last granted master.
- timeout  output  1  one-cycle pulse when the watchdog revokes or restarts a grant.

Behaviour:
- Reset (rst=1 at a clock edge):
  - grant=0, grantValid=0, timeout=0, hold counter=0, state=IDLE.
  - grantIndex=INPUTS-1, so requester 0 has first priority.
  - Reset wins over every other event, including mid-grant; no grant survives reset.
- All outputs are registered. Request-to-grant latency is 1 cycle.
- Invariants:
  - grant is 0 or exactly one-hot.
  - grantValid == |grant.
  - When grantValid=1, grantIndex is the encoded bit position of grant.
  - When grantValid=0, grantIndex holds the last granted index and serves as the priority pointer.
- Arbitration function: scan indices grantIndex+1, grantIndex+2, … modulo INPUTS, wrapping past INPUTS-1 to 0. Pick the first index whose request is set and which is not masked.
- State IDLE:
  - If request != 0: next cycle grant=onehot(winner), grantIndex=winner, counter=0, go to GRANTED.
  - Else stay in IDLE with grant=0.
- State GRANTED, release (request[grantIndex]=0):
  - Arbitrate the same cycle among the remaining requests.
  - If there is a winner: grant it next cycle, counter=0, stay in GRANTED. Back-to-back handover, no idle gap.
  - If there is none: grant=0 next cycle, go to IDLE.
- State GRANTED, still held (request[grantIndex]=1):
  - Increment the counter each cycle.
  - Other requests are ignored; no preemption except by the watchdog.
- Watchdog (TIMEOUT_CYCLES>0):
  - Trigger: counter==TIMEOUT_CYCLES-1 and request[grantIndex]=1.
  - timeout pulses high for one cycle, aligned with the next grant update.
  - Arbitrate with the current master masked out.
  - Other requester present: it is granted next cycle, counter=0.
  - No other requester: the current master stays granted, counter restarts at 0, and timeout still pulses.
  - Result: a lone master can be held indefinitely, with timeout pulsing every TIMEOUT_CYCLES cycles.
- Watchdog disabled (TIMEOUT_CYCLES=0): the counter never triggers and timeout stays 0.
- Simultaneous release and timeout in the same cycle: treated as a release; timeout does not pulse.
- A request bit that drops before being granted is simply not selected; no request queuing or latching.

Test Plan:
Configuration for all tests: INPUTS=4, TIMEOUT_CYCLES=8.
1. Release rst, then request=4'b1010 from cycle 0 → cycle 1: grant=4'b0010, grantIndex=1, grantValid=1. Drop request[1] → next cycle grant=4'b1000, grantIndex=3, no idle gap.
2. request=4'b1111, each master drops its request 2 cycles after being granted, then re-raises it → grant sequence 0001, 0010, 0100, 1000, 0001; no master is skipped or repeated.
3. Watchdog handover: request[0] held for 20 cycles with request[2] also high → grant=0001 for exactly 8 cycles, one-cycle timeout pulse, then grant=0100 on the following cycle.
4. Lone master: only request[0] held for 30 cycles → grant stays 0001 throughout, and timeout pulses every 8 cycles (3 pulses).
5. All requests drop while granted at index 2 → next cycle grant=0, grantValid=0, grantIndex=2. Then request=4'b0101 → grant=0001 (scan starts at index 3 and wraps to 0).
6. Reset mid-operation: assert rst while grant=0100 → next cycle grant=0, grantValid=0, timeout=0, grantIndex=3. Then request=4'b1111 → grant=0001.
